// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, converter FSM states and the most-negative test.
package alu_pkg;

  localparam int ALU_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } smag_state_t;

  // True when only bit width-1 of the low width bits of v is set.
  function automatic logic is_most_neg(input logic [ALU_WIDTH-1:0] v, input int width);
    logic r;
    r = v[width-1];
    for (int i = 0; i < ALU_WIDTH; i++) begin
      if (i < width - 1 && v[i]) r = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/sign_magnitude_decoder_chunk_negator.sv
// CHUNK-bit invert-plus-carry-in slice: {cout, sum} = ~slice + cin.
module chunk_negator #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] slice,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  always_comb begin
    {cout, sum} = {1'b0, ~slice} + {{CHUNK{1'b0}}, cin};
  end

endmodule

// File: rtl/sign_magnitude_decoder.sv
// Two's-complement to sign-magnitude converter, negating CHUNK bits per cycle LSB first.
// Optional one's-complement input mode is compiled in with SMAG_ONES_COMP_EN.
module sign_magnitude_decoder
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
`ifdef SMAG_ONES_COMP_EN
  input  logic             ones_mode,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign,
  output logic [WIDTH-1:0] mag,
  output logic             ovf
);

  localparam int NSLICES = WIDTH / CHUNK;
  localparam int IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

  smag_state_t       state, state_next;
  logic [WIDTH-1:0]  work;
  logic [IDX_W-1:0]  idx;
  logic              carry;
  logic [CHUNK-1:0]  neg_sum;
  logic              neg_cout;
  logic              accept;
  logic              init_carry;
  logic              init_ovf;

  assign accept = in_valid && in_ready;

`ifdef SMAG_ONES_COMP_EN
  // One's-complement: negation is a plain invert, and all ones flags negative zero.
  assign init_carry = ~ones_mode;
  assign init_ovf   = ones_mode ? (&a) : is_most_neg(ALU_WIDTH'(a), WIDTH);
`else
  assign init_carry = 1'b1;
  assign init_ovf   = is_most_neg(ALU_WIDTH'(a), WIDTH);
`endif

  chunk_negator #(.CHUNK(CHUNK)) u_negator (
    .slice (work[int'(idx)*CHUNK +: CHUNK]),
    .cin   (carry),
    .sum   (neg_sum),
    .cout  (neg_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = a[WIDTH-1] ? BUSY : DONE;
      end
      BUSY: begin
        if (idx == LAST_IDX) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every read in this edge sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: work is cleared too; it is one register, not a memory, so reset is cheap and keeps sims X-free.
      work  <= '0;
      idx   <= '0;
      carry <= 1'b0;
      sign  <= 1'b0;
      mag   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            work  <= a;
            sign  <= a[WIDTH-1];
            carry <= init_carry;
            idx   <= '0;
            if (!a[WIDTH-1]) begin
              mag <= a;
              ovf <= 1'b0;
            end else begin
              ovf <= init_ovf;
            end
          end
        end
        BUSY: begin
          // Carry out of the top slice falls off here; the next acceptance reloads carry.
          mag[int'(idx)*CHUNK +: CHUNK] <= neg_sum;
          carry <= neg_cout;
          idx   <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sign_magnitude_decoder.sv
// Self-checking bench for sign_magnitude_decoder: directed table, hand sequences, random vs. model.
module tb_sign_magnitude_decoder;

  localparam int W   = 64;
  localparam int LAT_NEG = W / 8 + 1;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic         out_valid;
  logic         out_ready;
  logic         sign;
  logic [W-1:0] mag;
  logic         ovf;
`ifdef SMAG_ONES_COMP_EN
  logic         ones_mode = 1'b0;
`endif

  int tests  = 0;
  int failed = 0;

  sign_magnitude_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
`ifdef SMAG_ONES_COMP_EN
    .ones_mode (ones_mode),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign      (sign),
    .mag       (mag),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic         sign;
    logic [W-1:0] mag;
    logic         ovf;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Reference: magnitude is the arithmetic absolute value; ovf when it does not fit a positive signed value.
  task automatic model(input logic [W-1:0] v, output vec_t r);
    r.a    = v;
    r.sign = $signed(v) < 0;
    r.mag  = r.sign ? (0 - v) : v;
    r.ovf  = r.sign && (r.mag == MOST_NEG);
    r.lat  = r.sign ? LAT_NEG : 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents v, waits for the result, checks it, holds out_ready low for hold cycles, then consumes it.
  task automatic run_op(input vec_t e, input int hold, input string tag);
    int cycles;
    logic [W-1:0] held_mag;
    check({tag, " in_ready_before"}, W'(in_ready), W'(1));
    a        = e.a;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = {$urandom, $urandom};
    cycles   = 1;
    while (!out_valid && cycles < 50) begin
      tick();
      cycles++;
    end
    check({tag, " latency"}, W'(cycles), W'(e.lat));
    check({tag, " sign"}, W'(sign), W'(e.sign));
    check({tag, " mag"}, mag, e.mag);
    check({tag, " ovf"}, W'(ovf), W'(e.ovf));
    held_mag = mag;
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " hold_valid"}, W'(out_valid), W'(1));
      check({tag, " hold_in_ready"}, W'(in_ready), W'(0));
      check({tag, " hold_mag"}, mag, held_mag);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " released"}, W'(out_valid), W'(0));
  endtask

  vec_t vecs[8];
  vec_t e;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;

    vecs[0] = '{64'h0000_0000_0000_0405, 1'b0, 64'h405, 1'b0, 1};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 64'h5, 1'b0, LAT_NEG};
    vecs[2] = '{64'h8000_0000_0000_0405, 1'b1, 64'h7FFF_FFFF_FFFF_FBFB, 1'b0, LAT_NEG};
    vecs[3] = '{64'h8000_0000_0000_0000, 1'b1, 64'h8000_0000_0000_0000, 1'b1, LAT_NEG};
    vecs[4] = '{64'h0, 1'b0, 64'h0, 1'b0, 1};
    vecs[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1};
    vecs[6] = '{64'h8000_0000_0000_0001, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, LAT_NEG};
    vecs[7] = '{64'hFFFF_FFFF_0000_0000, 1'b1, 64'h0000_0001_0000_0000, 1'b0, LAT_NEG};

    tick();
    tick();
    rst = 1'b0;
    check("reset in_ready", W'(in_ready), W'(1));
    check("reset out_valid", W'(out_valid), W'(0));
    check("reset sign", W'(sign), W'(0));
    check("reset mag", mag, '0);
    check("reset ovf", W'(ovf), W'(0));

    for (int i = 0; i < 8; i++) run_op(vecs[i], 0, $sformatf("vec%0d", i));

    // Backpressure with a second operand already waiting at the input.
    model(64'hFFFF_FFFF_FFFF_FFFF, e);
    a        = e.a;
    in_valid = 1'b1;
    tick();
    a = 64'h0000_0000_0000_0123;
    for (int i = 0; i < 60 && !out_valid; i++) tick();
    check("bp first sign", W'(sign), W'(1));
    check("bp first mag", mag, 64'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp hold valid", W'(out_valid), W'(1));
      check("bp hold in_ready", W'(in_ready), W'(0));
      check("bp hold sign", W'(sign), W'(1));
      check("bp hold mag", mag, 64'h1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp back to idle", W'(in_ready), W'(1));
    check("bp no valid", W'(out_valid), W'(0));
    tick();
    in_valid = 1'b0;
    check("bp second valid", W'(out_valid), W'(1));
    check("bp second mag", mag, 64'h123);
    check("bp second sign", W'(sign), W'(0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the fourth BUSY cycle abandons the operand.
    a        = 64'hFFF3_E73F_0000_0000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst mid out_valid", W'(out_valid), W'(0));
    check("rst mid in_ready", W'(in_ready), W'(1));
    check("rst mid mag", mag, '0);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) check("rst mid spurious valid", W'(out_valid), W'(0));
    end
    model(64'hFFFF_FFFF_FFFF_FFFE, e);
    run_op(e, 1, "after_rst");
    check("after_rst mag2", e.mag, 64'h2);

    // Random operands, biased toward negatives and the most-negative value.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] v;
      v = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: v = MOST_NEG;
        1: v = 0 - W'($urandom_range(1, 300));
        2: v[W-1] = 1'b0;
        default: ;
      endcase
      model(v, e);
      run_op(e, $urandom_range(0, 2), $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
